// File: rtl/prm_obstacle_accum.sv
// Streams obstacle codes into the shared checker bank and OR-accumulates the bank's
// edge masks into one blocked-edge vector per frame. Define PRM_ACC_COUNT_EN to build the frame-length counter.
module prm_obstacle_accum #(
    parameter int unsigned NUM_EDGES = 512,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [14:0]          in_code,
    input  logic                 in_last,
    output logic [14:0]          chk_code,
    input  logic [NUM_EDGES-1:0] chk_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_EDGES-1:0] out_mask,
    output logic [CNT_W-1:0]     out_count,
    output logic                 busy
);

    typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

    state_t               state, state_nx;
    logic                 s1_vld, s1_vld_nx;
    logic                 s1_last, s1_last_nx;
    logic [14:0]          code_nx;
    logic [NUM_EDGES-1:0] acc, acc_nx;
    logic [NUM_EDGES-1:0] out_mask_nx;
    logic                 out_valid_nx;
    logic                 in_ready_nx;
    logic                 busy_nx;
    logic                 accept;

`ifdef PRM_ACC_COUNT_EN
    logic [CNT_W-1:0]     count, count_nx, count_inc;
    logic [CNT_W-1:0]     out_count_nx;

    assign count_inc = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
`else
    logic                 frame_open, frame_open_nx;

    assign out_count = '0;
`endif

    assign accept = in_valid & in_ready & (state == ACCUM);

    // Next-state and datapath control; all outputs are registered from these values.
    always_comb begin
        state_nx     = state;
        s1_vld_nx    = 1'b0;
        s1_last_nx   = s1_last;
        code_nx      = chk_code;
        acc_nx       = acc;
        out_mask_nx  = out_mask;
        out_valid_nx = out_valid;
`ifdef PRM_ACC_COUNT_EN
        count_nx     = count;
        out_count_nx = out_count;
`else
        frame_open_nx = frame_open;
`endif

        // Stage 2: fold in the bank result for the code held in stage 1.
        if (s1_vld) begin
            acc_nx = acc | chk_mask;
`ifdef PRM_ACC_COUNT_EN
            count_nx = count_inc;
`endif
        end

        case (state)
            ACCUM: begin
                if (accept) begin
                    code_nx    = in_code;
                    s1_vld_nx  = 1'b1;
                    s1_last_nx = in_last;
`ifndef PRM_ACC_COUNT_EN
                    frame_open_nx = 1'b1;
`endif
                    if (in_last) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (s1_vld && s1_last) begin
                    state_nx     = DONE;
                    out_mask_nx  = acc | chk_mask;
                    out_valid_nx = 1'b1;
`ifdef PRM_ACC_COUNT_EN
                    out_count_nx = count_inc;
`endif
                end else begin
                    state_nx = ACCUM;
                end
                s1_last_nx = 1'b0;
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nx     = ACCUM;
                    acc_nx       = '0;
                    out_valid_nx = 1'b0;
`ifdef PRM_ACC_COUNT_EN
                    count_nx     = '0;
`else
                    frame_open_nx = 1'b0;
`endif
                end
            end
            default: state_nx = ACCUM;
        endcase

        // Ready only when settled in ACCUM, which leaves a one-cycle gap after each handoff.
        in_ready_nx = (state == ACCUM) && (state_nx == ACCUM);

`ifdef PRM_ACC_COUNT_EN
        busy_nx = s1_vld_nx | (count_nx != '0) | out_valid_nx;
`else
        busy_nx = s1_vld_nx | frame_open_nx | out_valid_nx;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            chk_code  <= '0;
            acc       <= '0;
            out_mask  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            s1_vld    <= s1_vld_nx;
            s1_last   <= s1_last_nx;
            chk_code  <= code_nx;
            acc       <= acc_nx;
            out_mask  <= out_mask_nx;
            out_valid <= out_valid_nx;
            in_ready  <= in_ready_nx;
            busy      <= busy_nx;
        end
    end

`ifdef PRM_ACC_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            out_count <= '0;
        end else begin
            count     <= count_nx;
            out_count <= out_count_nx;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_open <= 1'b0;
        end else begin
            frame_open <= frame_open_nx;
        end
    end
`endif

endmodule
